// File: rtl/adc_spi_pkg.sv
// Shared constants and state encoding for the ADC configuration SPI responder.
package adc_spi_pkg;

    localparam int FRAME_BITS = 24;
    localparam int CMD_BITS   = 8;
    localparam int DATA_BITS  = 16;
    localparam int ADDR_W     = 7;

    // R/W flag position within the full frame and within the command byte
    localparam int RW_BIT     = FRAME_BITS - 1;
    localparam int RW_CMD_BIT = RW_BIT - DATA_BITS;

    localparam logic [DATA_BITS-1:0] CHIP_ID_DEFAULT = 16'h0A19;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_CMD   = 3'd1;
    localparam state_t ST_WDATA = 3'd2;
    localparam state_t ST_RDATA = 3'd3;
    localparam state_t ST_TAIL  = 3'd4;

endpackage

// File: rtl/adc_spi_responder_sync.sv
// Oversampling front end: synchroniser chains for SCLK, CSn and MOSI plus edge detection.
module spi_in_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic spi_clk,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_n_s,
    output logic mosi_s
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_d;
    logic                   cs_d;

    // Deliberately not reset: a reset while CSn is held low must not fake a CSn fall.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        sclk_d    <= sclk_sync[SYNC_STAGES-1];
        cs_d      <= cs_sync[SYNC_STAGES-1];
    end

    assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_d;
    assign sclk_fall = ~sclk_sync[SYNC_STAGES-1] & sclk_d;
    assign cs_fall   = ~cs_sync[SYNC_STAGES-1] & cs_d;
    assign cs_rise   = cs_sync[SYNC_STAGES-1] & ~cs_d;
    assign cs_n_s    = cs_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder that shadows the ADC configuration registers and answers reads.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int                   NUM_REGS    = 16,
    parameter logic [DATA_BITS-1:0] CHIP_ID     = CHIP_ID_DEFAULT,
    parameter int                   SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     spi_cs_n,
    input  logic                     spi_clk,
    input  logic                     spi_mosi,
    output logic                     spi_miso,
    output logic                     spi_miso_oe,
    output logic                     wr_strobe,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_BITS-1:0]     wr_data,
    output logic                     rd_strobe,
    output logic                     frame_err,
    output logic [NUM_REGS*16-1:0]   regs_flat
);

    logic sclk_rise;
    logic sclk_fall;
    logic cs_fall;
    logic cs_rise;
    logic cs_n_s;
    logic mosi_s;

    spi_in_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .spi_clk  (spi_clk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .sclk_rise(sclk_rise),
        .sclk_fall(sclk_fall),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .cs_n_s   (cs_n_s),
        .mosi_s   (mosi_s)
    );

    state_t               state;
    logic [4:0]           bit_cnt;
    logic [DATA_BITS-2:0] shift_in;
    logic [DATA_BITS-1:0] shift_out;
    logic                 miso_q;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_BITS-1:0] regs [1:NUM_REGS-1];

    logic [CMD_BITS-1:0]  cmd_word;
    logic [DATA_BITS-1:0] data_word;
    logic [DATA_BITS-1:0] read_value;

    // Word views that include the bit arriving on the current SCLK rise.
    always_comb begin
        data_word  = {shift_in, mosi_s};
        cmd_word   = data_word[CMD_BITS-1:0];
        read_value = '0;
        if (cmd_word[ADDR_W-1:0] == '0) begin
            read_value = CHIP_ID;
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            if (cmd_word[ADDR_W-1:0] == ADDR_W'(i)) begin
                read_value = regs[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            miso_q    <= 1'b0;
            addr      <= '0;
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            for (int i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            wr_strobe <= 1'b0;
            rd_strobe <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        bit_cnt  <= '0;
                        shift_in <= '0;
                        miso_q   <= 1'b0;
                        state    <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (sclk_rise) begin
                        shift_in <= data_word[DATA_BITS-2:0];
                        if (bit_cnt == 5'(CMD_BITS - 1)) begin
                            bit_cnt <= '0;
                            addr    <= cmd_word[ADDR_W-1:0];
                            if (cmd_word[RW_CMD_BIT]) begin
                                state <= ST_WDATA;
                            end else begin
                                shift_out <= read_value;
                                rd_strobe <= 1'b1;
                                state     <= ST_RDATA;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_WDATA: begin
                    if (cs_rise) begin
                        frame_err <= 1'b1;
                        state     <= ST_IDLE;
                    end else if (sclk_rise) begin
                        shift_in <= data_word[DATA_BITS-2:0];
                        if (bit_cnt == 5'(DATA_BITS - 1)) begin
                            wr_strobe <= 1'b1;
                            wr_addr   <= addr;
                            wr_data   <= data_word;
                            for (int i = 1; i < NUM_REGS; i++) begin
                                if (addr == ADDR_W'(i)) begin
                                    regs[i] <= data_word;
                                end
                            end
                            state <= ST_TAIL;
                        end else begin
                            bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_RDATA: begin
                    // bit_cnt counts falls already driven; bit 0 stays on MISO until one more fall
                    if (cs_rise) begin
                        frame_err <= (bit_cnt < 5'(DATA_BITS));
                        state     <= ST_IDLE;
                    end else if (sclk_fall) begin
                        if (bit_cnt == 5'(DATA_BITS)) begin
                            miso_q <= 1'b0;
                            state  <= ST_TAIL;
                        end else begin
                            miso_q    <= shift_out[DATA_BITS-1];
                            shift_out <= {shift_out[DATA_BITS-2:0], 1'b0};
                            bit_cnt   <= bit_cnt + 5'd1;
                        end
                    end
                end
                ST_TAIL: begin
                    if (cs_rise) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign spi_miso_oe = ~cs_n_s && ((state == ST_RDATA) || (state == ST_TAIL));
    assign spi_miso    = spi_miso_oe && (state == ST_RDATA) && miso_q;

    assign regs_flat[DATA_BITS-1:0] = CHIP_ID;
    for (genvar g = 1; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[16*g +: 16] = regs[g];
    end

endmodule
